snax_hwpe_reg_slave: RTL



---
 rtl/snax_hwpe_reg_pkg.sv | 28 ++
 rtl/hwpe_ctrl_intf_periph.sv | 21 ++
 rtl/snax_hwpe_reg_slave.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/snax_hwpe_reg_pkg.sv
// Shared definitions for the HWPE register slave: register map indices,
// the job FSM state type and a byte-enable merge helper.
package snax_hwpe_reg_pkg;

  localparam int unsigned IDX_TRIGGER   = 0;
  localparam int unsigned IDX_STATUS    = 1;
  localparam int unsigned IDX_PERF      = 2;
  localparam int unsigned IDX_RESERVED  = 3;
  localparam int unsigned IDX_CFG_FIRST = 4;

  typedef enum logic [1:0] {
    JOB_IDLE    = 2'd0,
    JOB_START   = 2'd1,
    JOB_RUNNING = 2'd2
  } job_state_e;

  function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) res[8*k +: 8] = new_val[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/hwpe_ctrl_intf_periph.sv
// Peripheral request/response bus used to program the HWPE register file.
// wen=1 marks a read, wen=0 a write.
interface hwpe_ctrl_intf_periph #(
  parameter int unsigned ID_WIDTH = 5
);
  logic                req;
  logic                gnt;
  logic [31:0]         add;
  logic                wen;
  logic [3:0]          be;
  logic [31:0]         data;
  logic [ID_WIDTH-1:0] id;
  logic [31:0]         r_data;
  logic                r_valid;
  logic [ID_WIDTH-1:0] r_id;

  modport master (output req, add, wen, be, data, id,
                  input  gnt, r_data, r_valid, r_id);
  modport slave  (input  req, add, wen, be, data, id,
                  output gnt, r_data, r_valid, r_id);
endinterface

// File: rtl/snax_hwpe_reg_slave.sv
// HWPE register slave: trigger/status/perf registers, locked job config and job FSM.
// Optional cycle counter on idx2 enabled by defining SNAX_HWPE_REG_PERF_EN.
module snax_hwpe_reg_slave
  import snax_hwpe_reg_pkg::*;
#(
  parameter int unsigned NumRegs = 20,
  parameter int unsigned IdWidth = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  hwpe_ctrl_intf_periph.slave     periph,
  output logic [NumRegs*32-1:0]   reg_file_o,
  output logic                    start_o,
  input  logic                    done_i,
  output logic                    busy_o,
  output logic                    evt_o
);

  localparam int unsigned IdxW = $clog2(NumRegs);

  logic [29:0]        word_idx;
  logic [IdxW-1:0]    idx_lo;
  logic               in_range;
  logic               wr_req;
  logic               rd_req;
  logic               trigger;
  logic               cfg_we;
  logic               unused_addr_lsb;

  job_state_e         state_q;
  logic               start_q;
  logic               busy_q;
  logic               evt_q;
  logic [31:0]        perf_val;
  logic [31:0]        reg_view [NumRegs];
  logic [31:0]        cfg_q [IDX_CFG_FIRST:NumRegs-1];

  logic               r_valid_q;
  logic [31:0]        r_data_q;
  logic [31:0]        r_data_d;
  logic [IdWidth-1:0] r_id_q;

  assign word_idx        = periph.add[31:2];
  assign idx_lo          = word_idx[IdxW-1:0];
  assign in_range        = word_idx < 30'(NumRegs);
  assign unused_addr_lsb = ^periph.add[1:0];

  assign periph.gnt = periph.req;
  assign wr_req     = periph.req & ~periph.wen;
  assign rd_req     = periph.req & periph.wen;
  assign trigger    = wr_req & (word_idx == 30'(IDX_TRIGGER)) & (|periph.be);
  assign cfg_we     = wr_req & in_range & ~busy_q;

  for (genvar gi = IDX_CFG_FIRST; gi < NumRegs; gi++) begin : g_cfg
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cfg_q[gi] <= '0;
      end else if (cfg_we && idx_lo == IdxW'(gi)) begin
        cfg_q[gi] <= merge_be(cfg_q[gi], periph.data, periph.be);
      end
    end
  end

  // Software-visible view of every index; the read path and reg_file_o share it.
  for (genvar gi = 0; gi < NumRegs; gi++) begin : g_view
    if (gi == IDX_STATUS) begin : g_status
      assign reg_view[gi] = {31'b0, busy_q};
    end else if (gi == IDX_PERF) begin : g_perf
      assign reg_view[gi] = perf_val;
    end else if (gi >= IDX_CFG_FIRST) begin : g_cfgv
      assign reg_view[gi] = cfg_q[gi];
    end else begin : g_zero
      assign reg_view[gi] = '0;
    end
    assign reg_file_o[32*gi +: 32] = reg_view[gi];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= JOB_IDLE;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      evt_q   <= 1'b0;
      case (state_q)
        JOB_IDLE: begin
          if (trigger) begin
            state_q <= JOB_START;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        JOB_START: begin
          state_q <= JOB_RUNNING;
        end
        JOB_RUNNING: begin
          if (done_i) begin
            state_q <= JOB_IDLE;
            busy_q  <= 1'b0;
            evt_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= JOB_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign start_o = start_q;
  assign busy_o  = busy_q;
  assign evt_o   = evt_q;

`ifdef SNAX_HWPE_REG_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else if (state_q == JOB_START) begin
      perf_q <= '0;
    end else if (state_q == JOB_RUNNING && perf_q != 32'hFFFF_FFFF) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_val = perf_q;
`else
  assign perf_val = '0;
`endif

  assign r_data_d = in_range ? reg_view[idx_lo] : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_id_q    <= '0;
    end else begin
      r_valid_q <= rd_req;
      if (rd_req) begin
        r_data_q <= r_data_d;
        r_id_q   <= periph.id;
      end
    end
  end

  assign periph.r_valid = r_valid_q;
  assign periph.r_data  = r_data_q;
  assign periph.r_id    = r_id_q;

endmodule
